spi_regbank_peripheral: RTL and testbench

Parametrised SPI (mode 0) register-bank peripheral with write and read-back support. Sits behind the chip's dedicated input pins: it synchronises the asynchronous SCLK/COPI/nCS pins into the `clk` domain, decodes fixed-length frames, updates a bank of `NUM_REGS` control registers and drives read data on CIPO. Downstream blocks such as PWM and output enables consume the flattened register outputs.

---
 rtl/spi_regbank_peripheral.sv | 154 +++++++++++++++
 tb/tb_spi_regbank_peripheral.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_regbank_peripheral.sv
// spi_regbank_peripheral: SPI mode-0 slave that writes and reads back a bank of control registers.
// Ports: clk/rst_n (async active-low reset); sclk/copi/ncs (asynchronous SPI pins);
//        cipo/cipo_oe (read data and pad enable); regs_flat (register i at [i*DATA_W +: DATA_W]);
//        wr_strobe (one-cycle pulse per committed write); wr_addr (address of last committed write).
module spi_regbank_peripheral #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
);
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0]     sclk_sync_q, sclk_sync_d, copi_sync_q, copi_sync_d, ncs_sync_q, ncs_sync_d;
    logic                       sclk_hist_q, sclk_hist_d, ncs_hist_q, ncs_hist_d;
    logic [SYNC_STAGES:0]       ncs_vld_q, ncs_vld_d;
    logic                       sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
    logic                       ncs_rise_q, ncs_rise_d, ncs_fall_q, ncs_fall_d;
    logic                       copi_bit_q, copi_bit_d;
    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]       sh_q, sh_d;
    logic [DATA_W-1:0]          rd_q, rd_d;
    logic                       cipo_oe_q, cipo_oe_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic                       wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]          fr_addr, rd_addr;
    logic                       commit, rd_load, rd_hit;

    // Edges are registered once more so every pin-driven action lands SYNC_STAGES+1 edges after sampling.
    // ncs_vld masks ncs edges until the history flop holds a real sample, so the reset value of the
    // synchroniser cannot fake a falling edge when ncs is already low at reset release.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
        sclk_hist_d = sclk_sync_q[SYNC_STAGES-1];
        ncs_hist_d  = ncs_sync_q[SYNC_STAGES-1];
        ncs_vld_d   = {ncs_vld_q[SYNC_STAGES-1:0], 1'b1};
        sclk_rise_d = sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
        sclk_fall_d = ~sclk_sync_q[SYNC_STAGES-1] & sclk_hist_q;
        ncs_rise_d  = ncs_vld_q[SYNC_STAGES] & ncs_sync_q[SYNC_STAGES-1] & ~ncs_hist_q;
        ncs_fall_d  = ncs_vld_q[SYNC_STAGES] & ~ncs_sync_q[SYNC_STAGES-1] & ncs_hist_q;
        copi_bit_d  = copi_sync_q[SYNC_STAGES-1];
    end

    assign fr_addr = sh_q[DATA_W +: ADDR_W];
    assign rd_addr = sh_q[ADDR_W-1:0];
    assign commit  = cnt_q == CNT_W'(FRAME_LEN) && sh_q[FRAME_LEN-1]
                     && {1'b0, fr_addr} < (ADDR_W+1)'(NUM_REGS);
    assign rd_hit  = {1'b0, rd_addr} < (ADDR_W+1)'(NUM_REGS);
    assign rd_load = cnt_q == CNT_W'(1 + ADDR_W) && !sh_q[ADDR_W] && !cipo_oe_q;

    // An ncs rising edge takes priority over any sclk edge seen in the same cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        rd_d        = rd_q;
        cipo_oe_d   = cipo_oe_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        if (state_q == IDLE) begin
            if (ncs_fall_q) begin
                state_d = ACTIVE;
                cnt_d   = '0;
                sh_d    = '0;
            end
        end else if (ncs_rise_q) begin
            state_d   = IDLE;
            cipo_oe_d = 1'b0;
            rd_d      = '0;
            if (commit) begin
                regs_d[fr_addr*DATA_W +: DATA_W] = sh_q[DATA_W-1:0];
                wr_strobe_d = 1'b1;
                wr_addr_d   = fr_addr;
            end
        end else begin
            if (sclk_rise_q) begin
                sh_d  = {sh_q[FRAME_LEN-2:0], copi_bit_q};
                cnt_d = cnt_q == CNT_W'(FRAME_LEN + 1) ? cnt_q : cnt_q + 1'b1;
            end
            if (sclk_fall_q) begin
                rd_d      = rd_load ? (rd_hit ? regs_q[rd_addr*DATA_W +: DATA_W] : '0) : {rd_q[DATA_W-2:0], 1'b0};
                cipo_oe_d = cipo_oe_q | rd_load;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
            ncs_vld_q   <= '0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ncs_rise_q  <= 1'b0;
            ncs_fall_q  <= 1'b0;
            copi_bit_q  <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            rd_q        <= '0;
            cipo_oe_q   <= 1'b0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_hist_q <= sclk_hist_d;
            ncs_hist_q  <= ncs_hist_d;
            ncs_vld_q   <= ncs_vld_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            ncs_rise_q  <= ncs_rise_d;
            ncs_fall_q  <= ncs_fall_d;
            copi_bit_q  <= copi_bit_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rd_q        <= rd_d;
            cipo_oe_q   <= cipo_oe_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign cipo      = cipo_oe_q & rd_q[DATA_W-1];
    assign cipo_oe   = cipo_oe_q;
    assign regs_flat = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
endmodule

// File: tb/tb_spi_regbank_peripheral.sv
// tb_spi_regbank_peripheral: random and directed SPI frames on a default and a wide instance, checked against a register-array model.
module tb_spi_regbank_peripheral;
    localparam int H = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   sclk = 2'b00, copi = 2'b00, ncs = 2'b11;
    logic [1:0]   cipo, oe, wr_strobe;
    logic [39:0]  regs0;
    logic [255:0] regs1;
    logic [6:0]   wa0;
    logic [3:0]   wa1;
    int           n_chk = 0, n_pass = 0, st0 = 0, st1 = 0, lat;
    int           m_regs[2][16];
    int           m_wa[2];
    int           m_st[2];

    always #5 clk = ~clk;

    spi_regbank_peripheral dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk[0]), .copi(copi[0]), .ncs(ncs[0]),
        .cipo(cipo[0]), .cipo_oe(oe[0]), .regs_flat(regs0), .wr_strobe(wr_strobe[0]), .wr_addr(wa0)
    );

    spi_regbank_peripheral #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16), .SYNC_STAGES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk[1]), .copi(copi[1]), .ncs(ncs[1]),
        .cipo(cipo[1]), .cipo_oe(oe[1]), .regs_flat(regs1), .wr_strobe(wr_strobe[1]), .wr_addr(wa1)
    );

    always @(posedge clk) begin
        if (wr_strobe[0]) st0 <= st0 + 1;
        if (wr_strobe[1]) st1 <= st1 + 1;
    end

    function automatic int dw(int d); return d ? 16 : 8; endfunction
    function automatic int aw(int d); return d ? 4 : 7; endfunction
    function automatic int nr(int d); return d ? 16 : 5; endfunction
    function automatic int ss(int d); return d ? 3 : 2; endfunction

    function automatic logic [63:0] regs_val(int d, int i);
        return d ? 64'(regs1[i*16 +: 16]) : 64'(regs0[i*8 +: 8]);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_wa[d] = 0;
            for (int i = 0; i < 16; i++) m_regs[d][i] = 0;
        end
    endtask

    task automatic check_regs(input int d, input string tag);
        for (int i = 0; i < nr(d); i++) check(tag, regs_val(d, i), 64'(m_regs[d][i]));
        check({tag, "_wr_addr"}, d ? 64'(wa1) : 64'(wa0), 64'(m_wa[d]));
        check({tag, "_strobes"}, d ? 64'(st1) : 64'(st0), 64'(m_st[d]));
    endtask

    task automatic spi_bits(input int d, input int n, input logic [31:0] bits,
                            output logic [31:0] rx, output logic [31:0] oev);
        rx = '0;
        oev = '0;
        for (int i = 0; i < n; i++) begin
            copi[d] = bits[n-1-i];
            tick(H);
            sclk[d] = 1'b1;
            rx  = {rx[30:0], cipo[d]};
            oev = {oev[30:0], oe[d]};
            tick(H);
            sclk[d] = 1'b0;
        end
        tick(H);
    endtask

    function automatic logic [31:0] frame_bits(int d, int n, bit rw, int addr, int data);
        int f = 1 + aw(d) + dw(d);
        logic [31:0] full = (32'(rw) << (f - 1)) | (32'(addr) << dw(d)) | 32'(data);
        if (n < f) return full >> (f - n);
        return (full << (n - f)) | 32'($urandom_range(0, (1 << (n - f)) - 1));
    endfunction

    task automatic xfer(input int d, input int n, input bit rw, input int addr, input int data);
        int f = 1 + aw(d) + dw(d);
        logic [31:0] rx, oev, rdata, exp_rx, exp_oe;
        bit commit = n == f && rw && addr < nr(d);
        rdata = addr < nr(d) ? 32'(m_regs[d][addr]) : 32'h0;
        ncs[d] = 1'b0;
        tick(H);
        spi_bits(d, n, frame_bits(d, n, rw, addr, data), rx, oev);
        ncs[d] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (wr_strobe[d] && lat == 0) lat = k;
        end
        if (commit) begin
            m_regs[d][addr] = data;
            m_wa[d] = addr;
            m_st[d]++;
            check("commit_latency", 64'(lat), 64'(ss(d) + 2));
        end
        exp_rx = rw ? 32'h0 : (n < f ? rdata >> (f - n) : rdata << (n - f));
        exp_oe = rw ? 32'h0 : (32'h1 << (n - aw(d) - 1)) - 1;
        check("cipo_bits", 64'(rx), 64'(exp_rx));
        check("cipo_oe_bits", 64'(oev), 64'(exp_oe));
        check("cipo_oe_after", 64'(oe[d]), 64'h0);
        check_regs(d, "regs");
    endtask

    initial begin
        logic [31:0] rx, oev;
        int d, n, f;
        model_reset();
        m_st[0] = 0;
        m_st[1] = 0;
        tick(3);
        check("reset_regs0", 64'(regs0), 64'h0);
        check("reset_regs1", 64'(|regs1), 64'h0);
        check("reset_cipo", 64'(cipo), 64'h0);
        check("reset_oe", 64'(oe), 64'h0);
        check("reset_strobe", 64'(wr_strobe), 64'h0);
        rst_n = 1'b1;
        tick(10);
        xfer(0, 16, 1, 2, 'hA5);
        check("a5_flat", 64'(regs0), 64'h00_00A5_0000);
        xfer(0, 16, 1, 0, 'h3C);
        xfer(0, 16, 0, 0, 0);
        xfer(0, 16, 1, 5, 'hFF);
        xfer(0, 16, 0, 5, 0);
        xfer(0, 16, 1, 1, 'h11);
        xfer(0, 15, 1, 1, 'h22);
        xfer(0, 17, 1, 1, 'h33);
        xfer(0, 16, 1, 4, 'h01);
        xfer(0, 16, 1, 4, 'h02);
        // reset in the middle of a write to register 3, then pulses with ncs still low
        ncs[0] = 1'b0;
        tick(H);
        spi_bits(0, 10, frame_bits(0, 10, 1, 3, 'h99), rx, oev);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_regs0", 64'(regs0), 64'h0);
        check("midrst_wr_addr", 64'(wa0), 64'h0);
        check("midrst_cipo", 64'(cipo), 64'h0);
        check("midrst_oe", 64'(oe), 64'h0);
        check("midrst_strobe", 64'(wr_strobe), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        spi_bits(0, 16, frame_bits(0, 16, 1, 1, 'h77), rx, oev);
        ncs[0] = 1'b1;
        tick(12);
        check("ignored_oe", 64'(oev), 64'h0);
        check_regs(0, "ignored");
        xfer(0, 16, 1, 3, 'h5A);
        xfer(1, 21, 1, 15, 'hBEEF);
        xfer(1, 21, 0, 15, 0);
        for (int t = 0; t < 30; t++) begin
            d = $urandom_range(0, 1);
            f = 1 + aw(d) + dw(d);
            case ($urandom_range(0, 4))
                3: n = f - 1;
                4: n = f + 1;
                default: n = f;
            endcase
            xfer(d, n, 1'($urandom_range(0, 1)), $urandom_range(0, d ? 15 : 7),
                 $urandom_range(0, (1 << dw(d)) - 1));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
